// File: rtl/p_int_addsub_pipe_pkg.sv
// Shared types and helpers for the saturating integer add/sub pipeline.
package p_int_addsub_pipe_pkg;

  // Data format descriptor: bit width and signedness.
  typedef struct packed {
    logic [7:0] prec;
    logic       sign;
  } dconf_t;

  localparam dconf_t DEF_DCONF_INT = '{prec: 8'd16, sign: 1'b1};

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_t;

  // Largest value representable in format c.
  function automatic logic signed [63:0] dconf_max(input dconf_t c);
    if (c.sign) return (64'sd1 <<< (c.prec - 8'd1)) - 64'sd1;
    return (64'sd1 <<< c.prec) - 64'sd1;
  endfunction

  // Smallest value representable in format c.
  function automatic logic signed [63:0] dconf_min(input dconf_t c);
    if (c.sign) return -(64'sd1 <<< (c.prec - 8'd1));
    return 64'sd0;
  endfunction

endpackage

// File: rtl/p_int_addsub_pipe_sat_lane.sv
// One lane: exact add/sub of pre-extended operands, clamped to the output format.
module p_int_sat_lane
  import p_int_addsub_pipe_pkg::*;
#(
  parameter int     E      = 10,
  parameter dconf_t O_CONF = DEF_DCONF_INT,
  localparam int    O_PREC = int'(O_CONF.prec)
) (
  input  logic signed [E-1:0]      a,
  input  logic signed [E-1:0]      b,
  input  addsub_op_t               op,
  output logic        [O_PREC-1:0] res,
  output logic                     ovf
);

  localparam logic signed [63:0] O_MAX = dconf_max(O_CONF);
  localparam logic signed [63:0] O_MIN = dconf_min(O_CONF);

  logic signed [E-1:0] exact;
  logic signed [63:0]  wide;

  // Exact result (two headroom bits, never wraps), then clamp to [O_MIN, O_MAX].
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    res   = '0;
    ovf   = 1'b0;
    exact = (op == OP_SUB) ? (a - b) : (a + b);
    wide  = {{(64-E){exact[E-1]}}, exact};
    res   = wide[O_PREC-1:0];
    if (wide > O_MAX) begin
      res = O_MAX[O_PREC-1:0];
      ovf = 1'b1;
    end else if (wide < O_MIN) begin
      res = O_MIN[O_PREC-1:0];
      ovf = 1'b1;
    end
  end

endmodule

// File: rtl/p_int_addsub_pipe.sv
// Multi-lane saturating add/sub with a 2-stage valid/ready pipeline and
// per-lane sticky overflow counters.
module p_int_addsub_pipe
  import p_int_addsub_pipe_pkg::*;
#(
  parameter dconf_t I1_CONF = DEF_DCONF_INT,
  parameter dconf_t I2_CONF = DEF_DCONF_INT,
  parameter dconf_t O_CONF  = DEF_DCONF_INT,
  parameter int     LANES   = 4,
  parameter int     CNT_W   = 16,
  localparam int    I1_PREC = int'(I1_CONF.prec),
  localparam int    I2_PREC = int'(I2_CONF.prec),
  localparam int    O_PREC  = int'(O_CONF.prec)
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_op,
  input  logic [LANES*I1_PREC-1:0] in1,
  input  logic [LANES*I2_PREC-1:0] in2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*O_PREC-1:0]  out,
  output logic [LANES-1:0]         out_ovf,
  output logic [LANES*CNT_W-1:0]   ovf_cnt,
  input  logic                     cnt_clr
);

  localparam int E = ((I1_PREC > I2_PREC) ? I1_PREC : I2_PREC) + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                          s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  addsub_op_t                    s1_op_q, s1_op_d;
  logic [LANES-1:0][E-1:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [LANES-1:0][O_PREC-1:0]  lane_res, s2_out_q, s2_out_d;
  logic [LANES-1:0]              lane_ovf, s2_ovf_q, s2_ovf_d;
  logic [LANES-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [LANES-1:0]              cnt_inc;
  logic                          s2_adv, s2_load, in_fire, out_fire;

  // S2 can take new data when empty or draining; S1 likewise when S2 can.
  assign s2_adv    = !s2_v_q || out_ready;
  assign in_ready  = !s1_v_q || s2_adv;
  assign in_fire   = in_valid && in_ready;
  assign s2_load   = s1_v_q && s2_adv;
  assign out_fire  = s2_v_q && out_ready;
  assign cnt_inc   = {LANES{out_fire}} & s2_ovf_q;

  assign out_valid = s2_v_q;
  assign out       = s2_out_q;
  assign out_ovf   = s2_ovf_q;
  assign ovf_cnt   = cnt_q;

  // Stage occupancy: fill on accept/advance, empty when contents move on.
  always_comb begin
    s1_v_d = in_fire || (s1_v_q && !s2_adv);
    s2_v_d = s2_adv ? s1_v_q : s2_v_q;
  end

  // S1 capture: extend each operand to E bits according to its signedness.
  always_comb begin
    s1_op_d = s1_op_q;
    s1_a_d  = s1_a_q;
    s1_b_d  = s1_b_q;
    if (in_fire) begin
      s1_op_d = addsub_op_t'(in_op);
      for (int k = 0; k < LANES; k++) begin
        s1_a_d[k] = {{(E-I1_PREC){I1_CONF.sign & in1[k*I1_PREC+I1_PREC-1]}},
                     in1[k*I1_PREC +: I1_PREC]};
        s1_b_d[k] = {{(E-I2_PREC){I2_CONF.sign & in2[k*I2_PREC+I2_PREC-1]}},
                     in2[k*I2_PREC +: I2_PREC]};
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    p_int_sat_lane #(
      .E      (E),
      .O_CONF (O_CONF)
    ) u_sat (
      .a   (s1_a_q[k]),
      .b   (s1_b_q[k]),
      .op  (s1_op_q),
      .res (lane_res[k]),
      .ovf (lane_ovf[k])
    );
  end

  // S2 capture of the saturated lanes.
  always_comb begin
    s2_out_d = s2_load ? lane_res : s2_out_q;
    s2_ovf_d = s2_load ? lane_ovf : s2_ovf_q;
  end

  // Overflow counters: saturate at max; clear wins but keeps a same-cycle hit.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < LANES; k++) begin
      if (cnt_clr)
        cnt_d[k] = cnt_inc[k] ? CNT_W'(1) : '0;
      else if (cnt_inc[k] && (cnt_q[k] != CNT_MAX))
        cnt_d[k] = cnt_q[k] + 1'b1;
    end
  end

  // S1 operand registers; meaningful only while s1_v_q is set.
  always_ff @(posedge clk) begin
    // NOTE: pure data registers carry no reset; the valid bit qualifies them.
    s1_op_q <= s1_op_d;
    s1_a_q  <= s1_a_d;
    s1_b_q  <= s1_b_d;
  end

  // Valid bits, visible outputs and counters with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!reset_) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s2_out_q <= '0;
      s2_ovf_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      s2_out_q <= s2_out_d;
      s2_ovf_q <= s2_ovf_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_p_int_addsub_pipe.sv
// Scoreboard bench: drivers push expected beats, a negedge monitor pops on handshake.
module tb_p_int_addsub_pipe;
  import p_int_addsub_pipe_pkg::*;

  localparam dconf_t S8 = '{prec: 8'd8, sign: 1'b1};
  localparam dconf_t U8 = '{prec: 8'd8, sign: 1'b0};

  typedef struct {
    logic [15:0] out;
    logic [1:0]  ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  // signed/signed/signed instance
  logic        s_in_valid, s_in_ready, s_op, s_out_valid, s_out_ready, s_cnt_clr;
  logic [15:0] s_in1, s_in2, s_out;
  logic [1:0]  s_out_ovf;
  logic [7:0]  s_ovf_cnt;
  // unsigned-only and mixed instances share operand buses
  logic        x_op, x_out_ready, x_cnt_clr;
  logic [15:0] x_in1, x_in2;
  logic        u_in_valid, u_in_ready, u_out_valid, m_in_valid, m_in_ready, m_out_valid;
  logic [15:0] u_out, m_out;
  logic [1:0]  u_out_ovf, m_out_ovf;
  logic [7:0]  u_ovf_cnt, m_ovf_cnt;

  exp_t q_s[$], q_u[$], q_m[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  p_int_addsub_pipe #(.I1_CONF(S8), .I2_CONF(S8), .O_CONF(S8), .LANES(2), .CNT_W(4)) dut_s (
    .clk(clk), .reset_(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_op),
    .in1(s_in1), .in2(s_in2), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out(s_out), .out_ovf(s_out_ovf), .ovf_cnt(s_ovf_cnt), .cnt_clr(s_cnt_clr));

  p_int_addsub_pipe #(.I1_CONF(U8), .I2_CONF(U8), .O_CONF(U8), .LANES(2), .CNT_W(4)) dut_u (
    .clk(clk), .reset_(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready), .in_op(x_op),
    .in1(x_in1), .in2(x_in2), .out_valid(u_out_valid), .out_ready(x_out_ready),
    .out(u_out), .out_ovf(u_out_ovf), .ovf_cnt(u_ovf_cnt), .cnt_clr(x_cnt_clr));

  p_int_addsub_pipe #(.I1_CONF(U8), .I2_CONF(S8), .O_CONF(S8), .LANES(2), .CNT_W(4)) dut_m (
    .clk(clk), .reset_(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .in_op(x_op),
    .in1(x_in1), .in2(x_in2), .out_valid(m_out_valid), .out_ready(x_out_ready),
    .out(m_out), .out_ovf(m_out_ovf), .ovf_cnt(m_ovf_cnt), .cnt_clr(x_cnt_clr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  // One cycle on the signed instance; pushes the expected beat if accepted.
  task automatic cyc_s(input logic v, input logic op, input logic [15:0] a, input logic [15:0] b,
                       input logic ordy, input logic clr, input logic [15:0] eo,
                       input logic [1:0] eov, output logic acc);
    s_in_valid = v; s_op = op; s_in1 = a; s_in2 = b; s_out_ready = ordy; s_cnt_clr = clr;
    @(negedge clk);
    acc = v && s_in_ready;
    if (acc) q_s.push_back('{out: eo, ovf: eov});
    @(posedge clk); #1;
  endtask

  task automatic idle_s(input int n);
    logic a;
    for (int i = 0; i < n; i++) cyc_s(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0, 2'b00, a);
  endtask

  // One beat into the unsigned (vu) or mixed (vm) instance.
  task automatic cyc_x(input logic vu, input logic vm, input logic op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] eo, input logic [1:0] eov);
    u_in_valid = vu; m_in_valid = vm; x_op = op; x_in1 = a; x_in2 = b;
    @(negedge clk);
    if (vu) begin
      check("u_accept", 32'(u_in_ready), 32'd1);
      if (u_in_ready) q_u.push_back('{out: eo, ovf: eov});
    end
    if (vm) begin
      check("m_accept", 32'(m_in_ready), 32'd1);
      if (m_in_ready) q_m.push_back('{out: eo, ovf: eov});
    end
    @(posedge clk); #1;
    u_in_valid = 1'b0; m_in_valid = 1'b0;
  endtask

  // Monitor: compare every output handshake against the head of its queue.
  always @(negedge clk) begin
    if (s_out_valid && s_out_ready) begin
      if (q_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL s_unexpected_beat actual=%0h required=none @%0t", s_out, $time);
      end else begin
        mon_e = q_s.pop_front();
        check("s_out", 32'(s_out), 32'(mon_e.out));
        check("s_ovf", 32'(s_out_ovf), 32'(mon_e.ovf));
      end
    end
    if (u_out_valid && x_out_ready) begin
      if (q_u.size() == 0) begin
        checks++; errors++;
        $display("FAIL u_unexpected_beat actual=%0h required=none @%0t", u_out, $time);
      end else begin
        mon_e = q_u.pop_front();
        check("u_out", 32'(u_out), 32'(mon_e.out));
        check("u_ovf", 32'(u_out_ovf), 32'(mon_e.ovf));
      end
    end
    if (m_out_valid && x_out_ready) begin
      if (q_m.size() == 0) begin
        checks++; errors++;
        $display("FAIL m_unexpected_beat actual=%0h required=none @%0t", m_out, $time);
      end else begin
        mon_e = q_m.pop_front();
        check("m_out", 32'(m_out), 32'(mon_e.out));
        check("m_ovf", 32'(m_out_ovf), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   idx, stall_acc;
    rst_n = 1'b0;
    s_in_valid = 0; s_op = 0; s_in1 = 0; s_in2 = 0; s_out_ready = 0; s_cnt_clr = 0;
    x_op = 0; x_in1 = 0; x_in2 = 0; x_out_ready = 1; x_cnt_clr = 0;
    u_in_valid = 0; m_in_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_out_valid", 32'(s_out_valid), 32'd0);
    check("rst_out", 32'(s_out), 32'd0);
    check("rst_out_ovf", 32'(s_out_ovf), 32'd0);
    check("rst_cnt", 32'(s_ovf_cnt), 32'd0);
    check("rst_in_ready", 32'(s_in_ready), 32'd1);

    // Unsigned-only: 3-5 -> 0 ovf, 255-0 -> 255; 200+100 -> 255 ovf, 100+27 -> 127
    cyc_x(1, 0, 1'b1, {8'hFF, 8'h03}, {8'h00, 8'h05}, {8'hFF, 8'h00}, 2'b01);
    cyc_x(1, 0, 1'b0, {8'h64, 8'hC8}, {8'h1B, 8'h64}, {8'h7F, 8'hFF}, 2'b01);
    // Mixed: 200-(-100) -> 127 ovf, 5-10 -> -5; 255+(-128) -> 127, 0+(-128) -> -128
    cyc_x(0, 1, 1'b1, {8'h05, 8'hC8}, {8'h0A, 8'h9C}, {8'hFB, 8'h7F}, 2'b01);
    cyc_x(0, 1, 1'b0, {8'h00, 8'hFF}, {8'h80, 8'h80}, {8'h80, 8'h7F}, 2'b00);
    idle_s(4);

    // Signed saturation and latency: 127-(-1) -> 127, -128-1 -> -128
    cyc_s(1, 1'b1, {8'h80, 8'h7F}, {8'h01, 8'hFF}, 1, 0, {8'h80, 8'h7F}, 2'b11, acc);
    check("lat_accept", 32'(acc), 32'd1);
    check("lat_one_cycle", 32'(s_out_valid), 32'd0);
    idle_s(1);
    check("lat_two_cycles", 32'(s_out_valid), 32'd1);
    // Back-to-back signed beats
    cyc_s(1, 1'b0, {8'hFB, 8'h0A}, {8'h03, 8'h14}, 1, 0, {8'hFE, 8'h1E}, 2'b00, acc);
    cyc_s(1, 1'b0, {8'h9C, 8'h64}, {8'h9C, 8'h64}, 1, 0, {8'h80, 8'h7F}, 2'b11, acc);
    cyc_s(1, 1'b1, {8'hFF, 8'h00}, {8'h7F, 8'h80}, 1, 0, {8'h80, 8'h7F}, 2'b01, acc);
    cyc_s(1, 1'b0, {8'h80, 8'h7F}, {8'h00, 8'h00}, 1, 0, {8'h80, 8'h7F}, 2'b00, acc);
    idle_s(3);
    check("cnt_after_mix", 32'(s_ovf_cnt), 32'h23);

    // Counters: clear, then 20 lane0 overflows saturate at 15
    cyc_s(0, 0, 16'h0, 16'h0, 1, 1, 16'h0, 2'b00, acc);
    check("cnt_clear", 32'(s_ovf_cnt), 32'h00);
    for (int i = 0; i < 20; i++)
      cyc_s(1, 1'b0, {8'h01, 8'h7F}, {8'h01, 8'h01}, 1, 0, {8'h02, 8'h7F}, 2'b01, acc);
    idle_s(3);
    check("cnt_saturate", 32'(s_ovf_cnt), 32'h0F);
    // Clear coincident with an overflowing handshake keeps that hit
    cyc_s(1, 1'b0, {8'h01, 8'h7F}, {8'h01, 8'h01}, 1, 0, {8'h02, 8'h7F}, 2'b01, acc);
    idle_s(1);
    check("clr_hs_valid", 32'(s_out_valid), 32'd1);
    cyc_s(0, 0, 16'h0, 16'h0, 1, 1, 16'h0, 2'b00, acc);
    check("cnt_clr_with_hit", 32'(s_ovf_cnt), 32'h01);
    idle_s(2);

    // Backpressure: stall 5 cycles with in_valid held, incrementing data
    idx = 0; stall_acc = 0;
    for (int c = 0; c < 5; c++) begin
      cyc_s(1, 1'b0, {idx[7:0], idx[7:0]}, {8'h01, 8'h00}, 0, 0,
            {idx[7:0] + 8'd1, idx[7:0]}, 2'b00, acc);
      if (acc) begin idx++; stall_acc++; end
      if (c >= 1) begin
        check("bp_hold_valid", 32'(s_out_valid), 32'd1);
        check("bp_hold_out", 32'(s_out), 32'h0100);
      end
    end
    check("bp_stall_accepts", 32'(stall_acc), 32'd2);
    check("bp_in_ready_low", 32'(s_in_ready), 32'd0);
    for (int c = 0; c < 6; c++) begin
      cyc_s(1, 1'b0, {idx[7:0], idx[7:0]}, {8'h01, 8'h00}, 1, 0,
            {idx[7:0] + 8'd1, idx[7:0]}, 2'b00, acc);
      check("bp_full_rate", 32'(acc), 32'd1);
      if (acc) idx++;
    end
    idle_s(4);
    check("bp_drained", 32'(q_s.size()), 32'd0);

    // Reset mid-stream with two beats in flight
    cyc_s(1, 1'b0, {8'h01, 8'h7F}, {8'h01, 8'h01}, 0, 0, {8'h02, 8'h7F}, 2'b01, acc);
    cyc_s(1, 1'b0, {8'h01, 8'h7F}, {8'h01, 8'h01}, 0, 0, {8'h02, 8'h7F}, 2'b01, acc);
    rst_n = 1'b0;
    cyc_s(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 2'b00, acc);
    rst_n = 1'b1;
    q_s.delete();
    check("mrst_out_valid", 32'(s_out_valid), 32'd0);
    check("mrst_out", 32'(s_out), 32'd0);
    check("mrst_out_ovf", 32'(s_out_ovf), 32'd0);
    check("mrst_cnt", 32'(s_ovf_cnt), 32'd0);
    check("mrst_in_ready", 32'(s_in_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      idle_s(1);
      check("mrst_no_stale", 32'(s_out_valid), 32'd0);
    end

    check("end_q_s_empty", 32'(q_s.size()), 32'd0);
    check("end_q_u_empty", 32'(q_u.size()), 32'd0);
    check("end_q_m_empty", 32'(q_m.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
